l2_cache: RTL
=============

// Module: l2_cache
// PURPOSE
//  Responder end of the 256-bit line interface driven by the L1 arbiter (L2_read/L2_write/L2_addr/L2_wdata).
//  2-way set-associative, write-back, write-allocate line cache serving whole 32-byte lines.
//  Backs onto physical memory via an identical 256-bit initiator port (pmem_*).
//  Sits between the L1 arbiter and the memory model/controller.
// PARAMETERS
//  S_INDEX  4  index bits; SETS = 2**S_INDEX; tag = addr[31:5+S_INDEX], index = addr[4+S_INDEX:5]
// PORTS
//  clk         in   1    clock, all state on rising edge
//  rst_n       in   1    asynchronous, active-low reset
//  L2_read     in   1    line read request, held until L2_resp
//  L2_write    in   1    line write request (full line, no byte mask), held until L2_resp
//  L2_addr     in   32   line address; bits [4:0] ignored
//  L2_wdata    in   256  write line
//  L2_rdata    out  256  read line, valid while L2_resp=1
//  L2_resp     out  1    one-cycle completion pulse
//  pmem_read   out  1    memory line read, held until pmem_resp
//  pmem_write  out  1    memory line write, held until pmem_resp
//  pmem_addr   out  32   memory line address, [4:0]=0
//  pmem_wdata  out  256  victim line
//  pmem_rdata  in   256  fill line, valid with pmem_resp
//  pmem_resp   in   1    memory completion pulse
// BEHAVIOUR
//  Reset: state=IDLE; valid, dirty, lru all 0; L2_resp=0, L2_rdata=0, pmem_read=pmem_write=0, pmem_addr=0.
//   Tag/data arrays not reset. Async reset mid-transaction abandons the pmem access immediately.
//  FSM states: IDLE, CHECK, WRITEBACK, FILL, RESPOND.
//  IDLE: on L2_read|L2_write latch addr, wdata and op (write wins if both asserted) -> CHECK.
//  CHECK: hit = valid & tag match in either way.
//   read hit:  load rdata reg from hit way; lru[set] = other way -> RESPOND.
//   write hit: store wdata to hit way, dirty=1; lru[set] = other way -> RESPOND.
//   miss: victim = first invalid way (way0 before way1), else lru[set].
//    victim valid & dirty -> WRITEBACK; else read -> FILL; else write -> install wdata, valid=1, dirty=1 -> RESPOND.
//  WRITEBACK: pmem_write=1, pmem_addr={victim tag,index,5'b0}, pmem_wdata=victim data;
//   on pmem_resp: dirty=0; read -> FILL; write -> install as above -> RESPOND.
//  FILL: pmem_read=1, pmem_addr={req tag,index,5'b0}; on pmem_resp write pmem_rdata to victim,
//   valid=1, dirty=0, tag updated -> CHECK (re-check, guaranteed hit).
//  RESPOND: L2_resp=1 for exactly one cycle, L2_rdata = registered line -> IDLE.
//  Protocol: the initiator deasserts or changes its request in the cycle after L2_resp;
//   IDLE samples fresh request, so no double response.
//  Latency (request asserted in IDLE at cycle 0):
//   hit -> L2_resp at cycle 2.
//   clean read miss -> 2 + pmem latency + 2.
//   dirty miss adds the writeback transaction.
//  pmem_read and pmem_write never asserted together; pmem outputs are decoded from state and held stable while waiting.
//  L2_rdata holds last read line between responses; meaningless after write responses.
// STRUCTURE
//  l2_cache_pkg: state enum l2_state_t, line width 256, offset width 5, tag/index width helpers.
//  Sub-module l2_cache_way (tag, valid, dirty, data arrays for one way; 1 read port, sync write);
//   instantiated twice. FSM, LRU bits and muxing live in l2_cache.
// TESTING
//  1) Reset, read 0x0000_0040 (pmem returns line A after 3 cycles) -> one pmem_read @0x40, L2_rdata=A, single L2_resp.
//  2) Repeat read 0x40 -> no pmem activity, L2_resp exactly 2 cycles after request, data=A.
//  3) Write line B to 0x40, then evict by reading 0x240 and 0x440 (same set, S_INDEX=4) ->
//     pmem_write @0x40 with data B precedes pmem_read @0x440.
//  4) Write miss to clean set, 0x1000 line C -> no pmem_read; later read 0x1000 returns C with no pmem traffic.
//  5) LRU: fill 0x40 and 0x240, read 0x40, then read 0x440 -> victim is 0x240 (0x40 still hits).
//  6) Assert rst_n=0 mid-FILL -> pmem_read drops same cycle, L2_resp stays 0;
//     next read 0x40 misses (valid cleared).

Source files
------------

// File: rtl/l2_cache_pkg.sv
// Shared types and width helpers for the 2-way write-back L2 line cache.
package l2_cache_pkg;

   localparam int ADDR_W   = 32;
   localparam int LINE_W   = 256;
   localparam int OFFSET_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      WRITEBACK,
      FILL,
      RESPOND
   } l2_state_t;

   // Tag width left over once offset and index bits are removed.
   function automatic int tag_width(input int s_index);
      return ADDR_W - OFFSET_W - s_index;
   endfunction

endpackage

// File: rtl/l2_cache_way.sv
// One way of the cache: tag/data arrays plus per-set valid and dirty bits.
// Single read port addressed by the latched request index, synchronous write.
module l2_cache_way
   import l2_cache_pkg::*;
#(
   parameter int S_INDEX = 4,
   parameter int TAG_W   = tag_width(S_INDEX)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [S_INDEX-1:0] index,
   input  logic               wr_en,
   input  logic               wr_dirty,
   input  logic               clr_dirty,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [LINE_W-1:0]  wr_data,
   output logic [TAG_W-1:0]   tag,
   output logic [LINE_W-1:0]  data,
   output logic               valid,
   output logic               dirty
);

   localparam int SETS = 2 ** S_INDEX;

   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [LINE_W-1:0] data_mem [SETS];
   logic [SETS-1:0]   valid_reg;
   logic [SETS-1:0]   dirty_reg;

   // Tag and data storage; contents are qualified by valid so they need no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[index]  <= wr_tag;
         data_mem[index] <= wr_data;
      end
   end

   // Status bits: an install sets valid and loads dirty; install wins over a dirty clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= '0;
         dirty_reg <= '0;
      end else if (wr_en) begin
         valid_reg[index] <= 1'b1;
         dirty_reg[index] <= wr_dirty;
      end else if (clr_dirty) begin
         dirty_reg[index] <= 1'b0;
      end
   end

   assign tag   = tag_mem[index];
   assign data  = data_mem[index];
   assign valid = valid_reg[index];
   assign dirty = dirty_reg[index];

endmodule

// File: rtl/l2_cache.sv
// 2-way set-associative, write-back, write-allocate cache of 32-byte lines.
// Serves the L1 arbiter on the L2_* port and backs onto memory via pmem_*.
module l2_cache
   import l2_cache_pkg::*;
#(
   parameter int S_INDEX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              L2_read,
   input  logic              L2_write,
   input  logic [31:0]       L2_addr,
   input  logic [LINE_W-1:0] L2_wdata,
   output logic [LINE_W-1:0] L2_rdata,
   output logic              L2_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [31:0]       pmem_addr,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   localparam int TAG_W = tag_width(S_INDEX);
   localparam int SETS  = 2 ** S_INDEX;

   l2_state_t state_reg, state_next;

   logic [31:OFFSET_W]  line_addr_reg;
   logic [LINE_W-1:0]   wdata_reg;
   logic                write_reg;
   logic                victim_reg, victim_next;
   logic [LINE_W-1:0]   rdata_reg;
   logic [SETS-1:0]     lru_reg;

   logic [TAG_W-1:0]    req_tag;
   logic [S_INDEX-1:0]  req_index;
   logic                unused_offset;

   logic [TAG_W-1:0]    way_tag  [2];
   logic [LINE_W-1:0]   way_data [2];
   logic [1:0]          way_valid, way_dirty, way_hit;
   logic [1:0]          way_wr_en, way_clr_dirty;
   logic                way_wr_dirty;
   logic [LINE_W-1:0]   way_wr_data;

   logic                hit, hit_way, miss_victim;
   logic                latch_req, rdata_load, lru_we, lru_val;

   assign req_tag       = line_addr_reg[31:OFFSET_W+S_INDEX];
   assign req_index     = line_addr_reg[OFFSET_W+S_INDEX-1:OFFSET_W];
   // Byte offset within the line is a don't-care for whole-line accesses.
   assign unused_offset = ^L2_addr[OFFSET_W-1:0];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_way
         l2_cache_way #(.S_INDEX(S_INDEX)) u_way (
            .clk       (clk),
            .rst_n     (rst_n),
            .index     (req_index),
            .wr_en     (way_wr_en[gi]),
            .wr_dirty  (way_wr_dirty),
            .clr_dirty (way_clr_dirty[gi]),
            .wr_tag    (req_tag),
            .wr_data   (way_wr_data),
            .tag       (way_tag[gi]),
            .data      (way_data[gi]),
            .valid     (way_valid[gi]),
            .dirty     (way_dirty[gi])
         );
         assign way_hit[gi] = way_valid[gi] && (way_tag[gi] == req_tag);
      end
   endgenerate

   assign hit         = |way_hit;
   assign hit_way     = way_hit[1] && !way_hit[0];
   // Prefer an empty way (way0 first); otherwise evict the least recently used.
   assign miss_victim = !way_valid[0] ? 1'b0 :
                        !way_valid[1] ? 1'b1 : lru_reg[req_index];

   assign pmem_wdata  = way_data[victim_reg];
   assign L2_rdata    = rdata_reg;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state, array control and state-decoded port outputs.
   always_comb begin
      state_next    = state_reg;
      victim_next   = victim_reg;
      latch_req     = 1'b0;
      rdata_load    = 1'b0;
      lru_we        = 1'b0;
      lru_val       = 1'b0;
      way_wr_en     = '0;
      way_clr_dirty = '0;
      way_wr_dirty  = 1'b0;
      way_wr_data   = wdata_reg;
      L2_resp       = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr     = '0;
      case (state_reg)
         IDLE: begin
            if (L2_read || L2_write) begin
               latch_req  = 1'b1;
               state_next = CHECK;
            end
         end
         CHECK: begin
            if (hit) begin
               lru_we  = 1'b1;
               lru_val = ~hit_way;
               if (write_reg) begin
                  way_wr_en[hit_way] = 1'b1;
                  way_wr_dirty       = 1'b1;
               end else begin
                  rdata_load = 1'b1;
               end
               state_next = RESPOND;
            end else begin
               victim_next = miss_victim;
               if (way_valid[miss_victim] && way_dirty[miss_victim]) begin
                  state_next = WRITEBACK;
               end else if (!write_reg) begin
                  state_next = FILL;
               end else begin
                  // Full-line write miss: install directly, no fill needed.
                  way_wr_en[miss_victim] = 1'b1;
                  way_wr_dirty           = 1'b1;
                  lru_we                 = 1'b1;
                  lru_val                = ~miss_victim;
                  state_next             = RESPOND;
               end
            end
         end
         WRITEBACK: begin
            pmem_write = 1'b1;
            pmem_addr  = {way_tag[victim_reg], req_index, {OFFSET_W{1'b0}}};
            if (pmem_resp) begin
               way_clr_dirty[victim_reg] = 1'b1;
               if (write_reg) begin
                  way_wr_en[victim_reg] = 1'b1;
                  way_wr_dirty          = 1'b1;
                  lru_we                = 1'b1;
                  lru_val               = ~victim_reg;
                  state_next            = RESPOND;
               end else begin
                  state_next = FILL;
               end
            end
         end
         FILL: begin
            pmem_read = 1'b1;
            pmem_addr = {req_tag, req_index, {OFFSET_W{1'b0}}};
            if (pmem_resp) begin
               way_wr_en[victim_reg] = 1'b1;
               way_wr_data           = pmem_rdata;
               state_next            = CHECK;
            end
         end
         RESPOND: begin
            L2_resp    = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request latch, victim choice, LRU bits and the returned read line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_addr_reg <= '0;
         wdata_reg     <= '0;
         write_reg     <= 1'b0;
         victim_reg    <= 1'b0;
         rdata_reg     <= '0;
         lru_reg       <= '0;
      end else begin
         victim_reg <= victim_next;
         if (latch_req) begin
            line_addr_reg <= L2_addr[31:OFFSET_W];
            wdata_reg     <= L2_wdata;
            write_reg     <= L2_write;
         end
         if (rdata_load) rdata_reg <= way_data[hit_way];
         if (lru_we) lru_reg[req_index] <= lru_val;
      end
   end

endmodule
